// File: rtl/quadrature_cycle_decoder.sv
// Quadrature encoder to electrical cycle position decoder.
// Optional index alignment is enabled by defining INDEX_ALIGN_EN.
module quadrature_cycle_decoder #(
    parameter int COUNTS_PER_CYCLE = 1170,
    parameter int SYNC_STAGES      = 2,
    parameter int PERIOD_WIDTH     = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    enc_index,
    input  logic                    error_clear,
    output logic [10:0]             cycle_position,
    output logic                    direction,
    output logic [PERIOD_WIDTH-1:0] velocity_period,
    output logic                    velocity_valid,
    output logic                    error
);

    localparam logic [10:0] POS_MAX = 11'(COUNTS_PER_CYCLE - 1);
    localparam logic [10:0] POS_ONE = 11'd1;
    localparam logic [PERIOD_WIDTH-1:0] PER_MAX = '1;
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE = PERIOD_WIDTH'(1);

    logic [SYNC_STAGES-1:0]  a_sync;
    logic [SYNC_STAGES-1:0]  b_sync;
    logic [1:0]              ab_q;
    logic [1:0]              prev_ab;
    logic                    primed;
    logic [PERIOD_WIDTH-1:0] period_cnt;
    logic                    stalled;

    logic [1:0]              cur_bin;
    logic [1:0]              prev_bin;
    logic [1:0]              delta;
    logic                    step_fwd;
    logic                    step_rev;
    logic                    illegal;
    logic                    idx_rise;

    logic [10:0]             pos_nxt;
    logic                    dir_nxt;
    logic [PERIOD_WIDTH-1:0] cnt_nxt;
    logic [PERIOD_WIDTH-1:0] per_nxt;
    logic                    vld_nxt;
    logic                    stall_nxt;
    logic                    err_nxt;

    // Synchronizers are left unreset so they keep tracking the encoder
    // during reset and the prime value is already settled on release.
    always_ff @(posedge clk) begin
        a_sync <= {a_sync[SYNC_STAGES-2:0], enc_a};
        b_sync <= {b_sync[SYNC_STAGES-2:0], enc_b};
        ab_q   <= {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};
    end

`ifdef INDEX_ALIGN_EN
    logic [SYNC_STAGES-1:0] i_sync;
    logic                   idx_q;
    logic                   idx_prev;

    // Index synchronizer, delay-matched to the A/B path.
    always_ff @(posedge clk) begin
        i_sync <= {i_sync[SYNC_STAGES-2:0], enc_index};
        idx_q  <= i_sync[SYNC_STAGES-1];
    end

    // Previous index level for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) idx_prev <= 1'b0;
        else       idx_prev <= idx_q;
    end

    assign idx_rise = primed & idx_q & ~idx_prev;
`else
    logic unused_index;
    assign unused_index = enc_index;
    assign idx_rise     = 1'b0;
`endif

    // Gray state to 2-bit binary; the modular difference classifies the move.
    assign cur_bin  = {ab_q[1], ab_q[1] ^ ab_q[0]};
    assign prev_bin = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    assign delta    = cur_bin - prev_bin;
    assign step_fwd = primed && (delta == 2'd1);
    assign step_rev = primed && (delta == 2'd3);
    assign illegal  = primed && (delta == 2'd2);

    // Next-state logic for position, direction, period and error.
    always_comb begin
        pos_nxt   = cycle_position;
        dir_nxt   = direction;
        cnt_nxt   = (period_cnt == PER_MAX) ? PER_MAX : period_cnt + PER_ONE;
        per_nxt   = velocity_period;
        vld_nxt   = 1'b0;
        stall_nxt = stalled;
        err_nxt   = error;

        if (step_fwd)
            pos_nxt = (cycle_position == POS_MAX) ? 11'd0
                                                  : cycle_position + POS_ONE;
        else if (step_rev)
            pos_nxt = (cycle_position == 11'd0) ? POS_MAX
                                                : cycle_position - POS_ONE;

        if (idx_rise)
            pos_nxt = 11'd0;

        if (step_fwd || step_rev) begin
            dir_nxt   = step_fwd;
            cnt_nxt   = '0;
            stall_nxt = 1'b0;
            if (step_fwd == direction) begin
                per_nxt = (period_cnt == PER_MAX) ? PER_MAX
                                                  : period_cnt + PER_ONE;
                vld_nxt = 1'b1;
            end
        end else if (illegal) begin
            cnt_nxt   = '0;
            stall_nxt = 1'b0;
        end else if ((period_cnt == PER_MAX) && !stalled) begin
            per_nxt   = PER_MAX;
            vld_nxt   = 1'b1;
            stall_nxt = 1'b1;
        end

        if (illegal)
            err_nxt = 1'b1;
        else if (error_clear)
            err_nxt = 1'b0;
    end

    // State registers; the first cycle out of reset only primes prev_ab.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_ab         <= 2'b00;
            primed          <= 1'b0;
            cycle_position  <= 11'd0;
            direction       <= 1'b0;
            period_cnt      <= '0;
            velocity_period <= PER_MAX;
            velocity_valid  <= 1'b0;
            stalled         <= 1'b0;
            error           <= 1'b0;
        end else begin
            prev_ab         <= ab_q;
            primed          <= 1'b1;
            cycle_position  <= pos_nxt;
            direction       <= dir_nxt;
            period_cnt      <= cnt_nxt;
            velocity_period <= per_nxt;
            velocity_valid  <= vld_nxt;
            stalled         <= stall_nxt;
            error           <= err_nxt;
        end
    end

endmodule

// File: tb/tb_quadrature_cycle_decoder.sv
// Directed testbench for quadrature_cycle_decoder.
// Period counter is narrowed to 10 bits to keep stall tests short.
module tb_quadrature_cycle_decoder;

    localparam int PW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic          enc_a;
    logic          enc_b;
    logic          enc_index;
    logic          error_clear;
    logic [10:0]   cycle_position;
    logic          direction;
    logic [PW-1:0] velocity_period;
    logic          velocity_valid;
    logic          error;

    int vectors = 0;
    int errs    = 0;
    int vcnt    = 0;
    int vlast   = 0;
    int vmin    = 0;
    int vmax    = 0;

    logic [1:0] gray [4];
    logic [31:0] exp_idx;

    quadrature_cycle_decoder #(
        .COUNTS_PER_CYCLE(1170),
        .SYNC_STAGES(2),
        .PERIOD_WIDTH(PW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .enc_index(enc_index),
        .error_clear(error_clear),
        .cycle_position(cycle_position),
        .direction(direction),
        .velocity_period(velocity_period),
        .velocity_valid(velocity_valid),
        .error(error)
    );

    always #5 clk = ~clk;

    // Record every velocity_valid pulse seen away from the active edge.
    always @(negedge clk) begin
        if (velocity_valid) begin
            vcnt  = vcnt + 1;
            vlast = int'(velocity_period);
            if (int'(velocity_period) < vmin) vmin = int'(velocity_period);
            if (int'(velocity_period) > vmax) vmax = int'(velocity_period);
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input logic [1:0] ab);
        enc_a = ab[1];
        enc_b = ab[0];
    endtask

    task automatic clr_valid_stats();
        vcnt = 0;
        vlast = 0;
        vmin = 1 << 30;
        vmax = 0;
    endtask

    initial begin
        gray[0] = 2'b00;
        gray[1] = 2'b01;
        gray[2] = 2'b11;
        gray[3] = 2'b10;
        reset       = 1'b1;
        enc_index   = 1'b0;
        error_clear = 1'b0;
        set_ab(2'b11);
        wait_cyc(5);

        chk("rst_pos", 32'(cycle_position), 32'd0);
        chk("rst_dir", 32'(direction), 32'd0);
        chk("rst_per", 32'(velocity_period), 32'h3FF);
        chk("rst_vld", 32'(velocity_valid), 32'd0);
        chk("rst_err", 32'(error), 32'd0);

        // Release with A=B=1: priming must not flag anything.
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_cyc(1);
            chk("prime_pos", 32'(cycle_position), 32'd0);
        end
        chk("prime_err", 32'(error), 32'd0);

        // Restart from 00 and run two forward cycles at 50 clk per level.
        reset = 1'b1;
        set_ab(2'b00);
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);
        clr_valid_stats();
        for (int i = 1; i <= 8; i++) begin
            set_ab(gray[i % 4]);
            wait_cyc(50);
            chk("fwd_pos", 32'(cycle_position), 32'(i));
        end
        chk("fwd_dir", 32'(direction), 32'd1);
        chk("fwd_vcnt", 32'(vcnt), 32'd7);
        chk("fwd_vmin", 32'(vmin), 32'd50);
        chk("fwd_vmax", 32'(vmax), 32'd50);

        // Wrap in both directions.
        reset = 1'b1;
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);
        set_ab(2'b10);
        wait_cyc(10);
        chk("wrap_rev_pos", 32'(cycle_position), 32'd1169);
        chk("wrap_rev_dir", 32'(direction), 32'd0);
        set_ab(2'b11);
        wait_cyc(10);
        chk("rev_1168", 32'(cycle_position), 32'd1168);
        set_ab(2'b10);
        wait_cyc(10);
        chk("fwd_1169", 32'(cycle_position), 32'd1169);
        set_ab(2'b00);
        wait_cyc(10);
        chk("wrap_fwd_pos", 32'(cycle_position), 32'd0);
        chk("wrap_fwd_dir", 32'(direction), 32'd1);

        // Illegal transition 00 -> 11.
        set_ab(2'b11);
        wait_cyc(10);
        chk("ill_pos", 32'(cycle_position), 32'd0);
        chk("ill_err", 32'(error), 32'd1);
        wait_cyc(20);
        chk("ill_sticky", 32'(error), 32'd1);

        // Clear coincides with a second illegal transition: set wins.
        set_ab(2'b00);
        wait_cyc(3);
        error_clear = 1'b1;
        wait_cyc(1);
        error_clear = 1'b0;
        chk("setclr_err", 32'(error), 32'd1);
        chk("setclr_pos", 32'(cycle_position), 32'd0);
        wait_cyc(5);
        error_clear = 1'b1;
        wait_cyc(1);
        error_clear = 1'b0;
        wait_cyc(1);
        chk("clr_err", 32'(error), 32'd0);

        // Stall: one saturated report after a step, then silence.
        set_ab(2'b01);
        wait_cyc(5);
        chk("stall_step_pos", 32'(cycle_position), 32'd1);
        clr_valid_stats();
        wait_cyc(1100);
        chk("stall_vcnt", 32'(vcnt), 32'd1);
        chk("stall_per", 32'(vlast), 32'h3FF);

        // Forward, forward, reverse.
        clr_valid_stats();
        set_ab(2'b11);
        wait_cyc(20);
        chk("ffr1_vcnt", 32'(vcnt), 32'd1);
        chk("ffr1_per", 32'(vlast), 32'h3FF);
        set_ab(2'b10);
        wait_cyc(20);
        chk("ffr2_vcnt", 32'(vcnt), 32'd2);
        chk("ffr2_per", 32'(vlast), 32'd20);
        set_ab(2'b11);
        wait_cyc(20);
        chk("ffr3_vcnt", 32'(vcnt), 32'd2);
        chk("ffr3_dir", 32'(direction), 32'd0);
        chk("ffr3_pos", 32'(cycle_position), 32'd2);

        // Asynchronous reset mid-operation.
        #2;
        reset = 1'b1;
        set_ab(2'b00);
        #1;
        chk("async_rst_pos", 32'(cycle_position), 32'd0);
        chk("async_rst_per", 32'(velocity_period), 32'h3FF);
        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(5);

        // Walk to position 500, then index edge together with a step.
        for (int i = 1; i <= 500; i++) begin
            set_ab(gray[i % 4]);
            wait_cyc(4);
        end
        wait_cyc(4);
        chk("pos_500", 32'(cycle_position), 32'd500);
        enc_index = 1'b1;
        set_ab(2'b01);
        wait_cyc(10);
`ifdef INDEX_ALIGN_EN
        exp_idx = 32'd0;
`else
        exp_idx = 32'd501;
`endif
        chk("index_pos", 32'(cycle_position), exp_idx);
        chk("index_dir", 32'(direction), 32'd1);
        chk("index_err", 32'(error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
